// File: rtl/mycpu_pkg.sv
// mycpu_pkg: types and constants shared by the CPU datapath blocks.
//   LD_* : load-type encodings carried on in_ldtype (5..7 behave as LW)
//   wb_state_t : writeback stage FSM states
//   ld_misaligned() : alignment rule for loads, shared by writeback and load_align
package mycpu_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Byte loads never fault; halfwords need an even address; words (and the
  // unused encodings, which behave as words) need a word-aligned address.
  function automatic logic ld_misaligned(input logic [2:0] ldtype,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (ldtype)
      LD_LB, LD_LBU: mis = 1'b0;
      LD_LH, LD_LHU: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational sub-word extraction for loads.
//   ldtype_i     : load type (LD_* encodings)
//   addr_lo_i    : low two bits of the effective address
//   rdata_i      : little-endian read word from data memory
//   data_o       : selected byte/half/word, sign- or zero-extended to 32 bits
//   misaligned_o : access violates the alignment rule for its type
module load_align
  import mycpu_pkg::*;
(
  input  logic [2:0]  ldtype_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte/half and extend it according to the load type.
  always_comb begin
    shifted_s = rdata_i >> {addr_lo_i, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ldtype_i)
      LD_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      LD_LBU:  data_o = {24'd0, byte_s};
      LD_LH:   data_o = {{16{half_s[15]}}, half_s};
      LD_LHU:  data_o = {16'd0, half_s};
      default: data_o = rdata_i;
    endcase
    misaligned_o = ld_misaligned(ldtype_i, addr_lo_i);
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the register file's single write port.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake (ready only while IDLE)
//   in_*              : retiring instruction (ALU result / load address, dest select, load type)
//   mem_rvalid/rdata  : data-memory read return, one-cycle pulse
//   wr_en/addr/data   : registered register-file write
//   pend_valid/addr   : destination of an outstanding writing load (for load-use stall)
//   err_align/timeout/stray : sticky error flags, cleared only by rst
module wb_stage
  import mycpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_aluresult,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_regdst,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic [2:0]  in_ldtype,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        pend_valid,
  output logic [4:0]  pend_addr,
  output logic        err_align,
  output logic        err_timeout,
  output logic        err_stray
);

  wb_state_t   state_q, state_d;
  logic [4:0]  dst_q;
  logic [2:0]  ldtype_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic [7:0]  cnt_q;
  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic        err_align_q, err_timeout_q, err_stray_q;

  logic        accept_s;
  logic [4:0]  dst_s;
  logic        wen_s;
  logic        timeout_s;
  logic [31:0] ld_data_s;
  logic        ld_mis_s;

  assign accept_s  = in_valid && in_ready;
  assign dst_s     = in_regdst ? in_rd : in_rt;
  assign wen_s     = in_regwrite && (dst_s != 5'd0);
  // Last allowed wait cycle: the load has spent TIMEOUT cycles in WAIT_MEM.
  assign timeout_s = (state_q == WAIT_MEM) && !mem_rvalid &&
                     (cnt_q == 8'(TIMEOUT - 1));

  load_align u_load_align (
    .ldtype_i     (ldtype_q),
    .addr_lo_i    (addr_lo_q),
    .rdata_i      (mem_rdata),
    .data_o       (ld_data_s),
    .misaligned_o (ld_mis_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && in_memtoreg) state_d = WAIT_MEM;
        else                         state_d = IDLE;
      end
      WAIT_MEM: begin
        if (mem_rvalid || timeout_s) state_d = IDLE;
        else                         state_d = WAIT_MEM;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state-decoded outputs; a non-writing load does not stall decode.
  always_comb begin
    in_ready   = 1'b0;
    pend_valid = 1'b0;
    pend_addr  = 5'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      WAIT_MEM: begin
        pend_valid = we_q;
        pend_addr  = dst_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Load context capture, wait counter, registered write port and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q         <= 5'd0;
      ldtype_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      we_q          <= 1'b0;
      cnt_q         <= 8'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 5'd0;
      wr_data_q     <= 32'd0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept_s) begin
        if (in_memtoreg) begin
          dst_q     <= dst_s;
          ldtype_q  <= in_ldtype;
          addr_lo_q <= in_aluresult[1:0];
          we_q      <= wen_s;
          cnt_q     <= 8'd0;
          if (ld_misaligned(in_ldtype, in_aluresult[1:0])) err_align_q <= 1'b1;
        end else begin
          wr_en_q   <= wen_s;
          wr_addr_q <= dst_s;
          wr_data_q <= in_aluresult;
        end
      end
      if (state_q == WAIT_MEM) begin
        if (mem_rvalid) begin
          wr_en_q   <= we_q && !ld_mis_s;
          wr_addr_q <= dst_q;
          wr_data_q <= ld_data_s;
        end else if (timeout_s) begin
          err_timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else if (mem_rvalid) begin
        // Read data with no outstanding load (including the accept cycle).
        err_stray_q <= 1'b1;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;
  assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_aluresult;
  logic [4:0]  in_rt, in_rd;
  logic        in_regdst, in_regwrite, in_memtoreg;
  logic [2:0]  in_ldtype;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        err_align, err_timeout, err_stray;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_stage #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluresult (in_aluresult),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_regdst    (in_regdst),
    .in_regwrite  (in_regwrite),
    .in_memtoreg  (in_memtoreg),
    .in_ldtype    (in_ldtype),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pend_valid   (pend_valid),
    .pend_addr    (pend_addr),
    .err_align    (err_align),
    .err_timeout  (err_timeout),
    .err_stray    (err_stray)
  );

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid     = 1'b0;
    in_aluresult = 32'd0;
    in_rt        = 5'd0;
    in_rd        = 5'd0;
    in_regdst    = 1'b0;
    in_regwrite  = 1'b0;
    in_memtoreg  = 1'b0;
    in_ldtype    = 3'd0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'd0;
  endtask

  task automatic set_instr(input logic [31:0] alu, input logic [4:0] rt,
                           input logic [4:0] rd, input logic regdst,
                           input logic regwrite, input logic memtoreg,
                           input logic [2:0] ldtype);
    in_valid     = 1'b1;
    in_aluresult = alu;
    in_rt        = rt;
    in_rd        = rd;
    in_regdst    = regdst;
    in_regwrite  = regwrite;
    in_memtoreg  = memtoreg;
    in_ldtype    = ldtype;
  endtask

  task automatic test_reset();
    logic [49:0] obs;
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
    obs = {wr_en, wr_addr, wr_data, pend_valid, pend_addr, err_align, err_timeout, err_stray, in_ready};
    tests_run++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", obs,
               {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_nonload();
    set_instr(32'h0000_1234, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    clear_in();
    tests_run++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      tests_failed++;
      $display("FAIL nonload_write: got en=%b addr=%0d data=%h expected en=1 addr=5 data=00001234",
               wr_en, wr_addr, wr_data);
    end
    tick();
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL nonload_idle_after: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [3];
    logic [31:0] vals  [3];
    addrs = '{5'd3, 5'd12, 5'd31};
    vals  = '{32'hDEAD_0001, 32'h0000_0002, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      // Alternate rd/rt destination selection.
      if (i == 1) set_instr(vals[i], addrs[i], 5'd9, 1'b0, 1'b1, 1'b0, 3'd0);
      else        set_instr(vals[i], 5'd9, addrs[i], 1'b1, 1'b1, 1'b0, 3'd0);
      tick();
      tests_run++;
      if ({wr_en, wr_addr, wr_data, in_ready} !== {1'b1, addrs[i], vals[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_write%0d: got en=%b addr=%0d data=%h ready=%b expected en=1 addr=%0d data=%h ready=1",
                 i, wr_en, wr_addr, wr_data, in_ready, addrs[i], vals[i]);
      end
    end
    clear_in();
    tick();
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_reg0();
    set_instr(32'h0000_5555, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_in();
      tests_run++;
      if (wr_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL reg0_no_write cycle%0d: got wr_en=%b expected 0", i, wr_en);
      end
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] ldtype,
                           input logic [1:0] addr_lo, input logic [31:0] exp);
    set_instr({28'h0000_100, 2'b00, addr_lo}, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, ldtype);
    tick();
    clear_in();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({pend_valid, pend_addr, in_ready, wr_en} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s_pending cycle%0d: got pv=%b pa=%0d ready=%b en=%b expected pv=1 pa=7 ready=0 en=0",
                 name, k, pend_valid, pend_addr, in_ready, wr_en);
      end
      if (k == 3) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80AB_CDEF;
      end
      tick();
    end
    clear_in();
    tests_run++;
    if ({wr_en, wr_addr, wr_data, in_ready, pend_valid} !== {1'b1, 5'd7, exp, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s_write: got en=%b addr=%0d data=%h ready=%b pv=%b expected en=1 addr=7 data=%h ready=1 pv=0",
               name, wr_en, wr_addr, wr_data, in_ready, pend_valid, exp);
    end
  endtask

  task automatic test_misaligned();
    set_instr(32'h0000_2002, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    clear_in();
    tests_run++;
    if ({err_align, in_ready} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL align_flag: got err_align=%b ready=%b expected 1 0", err_align, in_ready);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    clear_in();
    tests_run++;
    if ({wr_en, in_ready, err_align, err_stray} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL align_no_write: got en=%b ready=%b err_align=%b err_stray=%b expected 0 1 1 0",
               wr_en, in_ready, err_align, err_stray);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    logic saw_write;
    cycles    = 0;
    saw_write = 1'b0;
    set_instr(32'h0000_3000, 5'd10, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0);
    tick();
    clear_in();
    while (in_ready === 1'b0 && cycles < 40) begin
      tick();
      cycles++;
      if (wr_en !== 1'b0) saw_write = 1'b1;
    end
    tests_run++;
    if (cycles != 15) begin
      tests_failed++;
      $display("FAIL timeout_cycles: got %0d cycles until ready expected 15", cycles);
    end
    tests_run++;
    if ({err_timeout, pend_valid, saw_write, err_stray} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_flags: got err_timeout=%b pv=%b wrote=%b err_stray=%b expected 1 0 0 0",
               err_timeout, pend_valid, saw_write, err_stray);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_5555;
    tick();
    clear_in();
    tests_run++;
    if ({err_stray, wr_en} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL stray_after_timeout: got err_stray=%b en=%b expected 1 0", err_stray, wr_en);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [49:0] obs;
    set_instr(32'h0000_4000, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    clear_in();
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    tick();
    rst = 1'b0;
    clear_in();
    obs = {wr_en, wr_addr, wr_data, pend_valid, pend_addr, err_align, err_timeout, err_stray, in_ready};
    tests_run++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL midwait_reset: got %h expected %h", obs,
               {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    tick();
    clear_in();
    tests_run++;
    if ({wr_en, err_stray} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL midwait_late_rvalid: got en=%b err_stray=%b expected 0 1", wr_en, err_stray);
    end
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_back_to_back();
    test_reg0();
    test_load("lb",  3'd1, 2'd3, 32'hFFFF_FF80);
    test_load("lbu", 3'd2, 2'd3, 32'h0000_0080);
    test_load("lh",  3'd3, 2'd2, 32'hFFFF_80AB);
    test_load("lhu", 3'd4, 2'd0, 32'h0000_CDEF);
    test_load("lw",  3'd0, 2'd0, 32'h80AB_CDEF);
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that drives the register file's single write port. Captures each retiring instruction's ALU result and destination selection, waits for variable-latency data-memory read data on loads, extracts and sign/zero-extends sub-word load data, and issues exactly one registered write per instruction. Sits between the data-memory interface and the register file; also reports the in-flight load destination so decode can stall on a load-use hazard.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in WAIT_MEM before the load is abandoned (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_aluresult  in  32  ALU result, or the effective address for loads.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_regdst  in  1  1: destination is rd; 0: destination is rt.
- in_regwrite  in  1  instruction writes a register.
- in_memtoreg  in  1  instruction is a load.
- in_ldtype  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- mem_rvalid  in  1  read data valid, one-cycle pulse.
- mem_rdata  in  32  read word, little-endian (byte 0 = bits 7:0).
- wr_en  out  1  register-file write enable.
- wr_addr  out  5  write address.
- wr_data  out  32  write data.
- pend_valid  out  1  a load is outstanding.
- pend_addr  out  5  destination of the outstanding load.
- err_align  out  1  sticky: misaligned LW/LH/LHU seen.
- err_timeout  out  1  sticky: load abandoned on timeout.
- err_stray  out  1  sticky: mem_rvalid while IDLE.

## Operation
- States: IDLE, WAIT_MEM. in_ready = (state == IDLE).
- Accept when in_valid && in_ready. Destination dst = in_regdst ? in_rd : in_rt; effective write = in_regwrite && dst != 0.
- Non-load accepted at cycle N: at N+1 wr_en = effective write, wr_addr = dst, wr_data = in_aluresult. State stays IDLE; back-to-back acceptance allowed every cycle.
- Load accepted at cycle N: state -> WAIT_MEM at N+1; dst, ldtype and in_aluresult[1:0] captured. pend_valid = 1 and pend_addr = dst during WAIT_MEM. pend_valid = 0 when the load does not write (regwrite = 0 or dst = 0).
- WAIT_MEM, mem_rvalid = 1 at cycle M: at M+1 wr_en = effective write and not misaligned, wr_data = extracted value, state -> IDLE, in_ready = 1.
- Extraction by addr_lo: LB/LBU select byte addr_lo, sign/zero-extended to 32; LH/LHU select half addr_lo[1], sign/zero-extended; LW is the whole word.
- Misaligned: LW with addr_lo != 0, or LH/LHU with addr_lo[0] = 1. err_align is set at acceptance. The stage still waits for mem_rvalid; the write is suppressed.
- Timeout: a wait counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_rvalid. When it reaches TIMEOUT: state -> IDLE, err_timeout = 1, no write, pend_valid = 0.
- mem_rvalid while IDLE: ignored, err_stray = 1. A mem_rvalid in the same cycle as a load is accepted belongs to nothing and counts as stray.
- wr_en is 0 in every cycle not listed above. Error flags clear only on rst.

## Timing
- All outputs are registered except in_ready and pend_*, which decode from state.
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, pend_valid 0, pend_addr 0, all err_* 0, wait counter 0. in_ready = 1 in the cycle after reset.
- rst asserted mid-WAIT_MEM: the load is dropped with no write. A mem_rvalid arriving after reset is counted as stray.
- Latency: non-load 1 cycle from acceptance to wr_en. Load 1 cycle from mem_rvalid to wr_en. Minimum load occupancy is 2 cycles, because mem_rvalid is sampled no earlier than N+1.

## Structure
- Shared package mycpu_pkg: LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU constants, wb_state_t enum {IDLE, WAIT_MEM}.
- One combinational sub-module, load_align (ldtype, addr_lo, rdata -> data, misaligned), reused later by the store-side byte-enable logic.

## Test plan
- Non-load add, regdst = 1, rd = 5, aluresult 0x1234 -> next cycle wr_en = 1, wr_addr = 5, wr_data = 0x0000_1234. Three back-to-back instructions give three consecutive writes.
- Write to register 0: regdst = 0, rt = 0 -> wr_en stays 0 throughout.
- LB, addr_lo = 3, rdata 0x80AB_CDEF, dst = 7, rvalid 4 cycles after acceptance -> pend_valid = 1 and pend_addr = 7 for 4 cycles, then wr_data = 0xFFFF_FF80. The same access as LBU gives 0x0000_0080. LH with addr_lo = 2 gives 0xFFFF_80AB.
- LW with addr_lo = 2 -> err_align = 1, then rvalid arrives -> no write, return to IDLE.
- Load with no rvalid -> after TIMEOUT = 15 cycles err_timeout = 1 and in_ready = 1. A later rvalid sets err_stray = 1 and produces no write.
- rst in the 2nd WAIT_MEM cycle -> all outputs at reset values next cycle, and no write occurs.
